// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity modes and baud defaults
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Parity over the low 'bits' data bits; even mode returns the XOR so the 1s total is even.
  function automatic logic parity_bit(input logic [7:0] data, input int bits, input int mode);
    logic [7:0] mask;
    mask = 8'hFF >> (8 - bits);
    return (mode == PAR_ODD) ? ~^(data & mask) : ^(data & mask);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit cycle counter with clear and one-cycle bit_done
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit serializer: start, data LSB first, parity, stop
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] word,
  input  logic       connection_status,
  output logic       txd,
  output logic       transmit_ready,
  output logic       busy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic       par, par_n;
  logic       txd_n, busy_n, ready_n;
  logic       bit_done;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      shift          <= '0;
      idx            <= '0;
      par            <= 1'b0;
      txd            <= 1'b1;
      busy           <= 1'b0;
      transmit_ready <= 1'b0;
    end else begin
      state          <= state_n;
      shift          <= shift_n;
      idx            <= idx_n;
      par            <= par_n;
      txd            <= txd_n;
      busy           <= busy_n;
      transmit_ready <= ready_n;
    end
  end

  // txd is registered, so each transition loads the level of the bit that follows it.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    par_n   = par;
    txd_n   = txd;
    busy_n  = busy;
    ready_n = 1'b0;
    case (state)
      S_IDLE: begin
        txd_n  = 1'b1;
        busy_n = 1'b0;
        if (connection_status) begin
          shift_n = word;
          par_n   = parity_bit(word, DATA_BITS, PARITY);
          txd_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: if (bit_done) begin
        state_n = S_DATA;
        idx_n   = '0;
        txd_n   = shift[0];
      end
      S_DATA: if (bit_done) begin
        shift_n = shift >> 1;
        if (idx == LAST_DATA) begin
          idx_n = '0;
          if (PARITY != PAR_NONE) begin
            state_n = S_PARITY;
            txd_n   = par;
          end else begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end
        end else begin
          idx_n = idx + 3'd1;
          txd_n = shift[1];
        end
      end
      S_PARITY: if (bit_done) begin
        state_n = S_STOP;
        idx_n   = '0;
        txd_n   = 1'b1;
      end
      S_STOP: if (bit_done) begin
        if (idx == LAST_STOP) begin
          state_n = S_IDLE;
          idx_n   = '0;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       connection_status;
  logic [7:0] word;
  logic [3:0] txd_a, rdy_a, busy_a;

  int checks = 0;
  int errors = 0;

  logic [127:0] tx_v[4];
  logic [127:0] rdy_v[4];
  logic [127:0] bsy_v[4];

  always #5 clk = ~clk;

  // Instances: 0 = no parity, 1 = even, 2 = odd, 3 = two stop bits.
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rst(rst), .word(word), .connection_status(connection_status),
    .txd(txd_a[0]), .transmit_ready(rdy_a[0]), .busy(busy_a[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .word(word), .connection_status(connection_status),
    .txd(txd_a[1]), .transmit_ready(rdy_a[1]), .busy(busy_a[1]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .word(word), .connection_status(connection_status),
    .txd(txd_a[2]), .transmit_ready(rdy_a[2]), .busy(busy_a[2]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .word(word), .connection_status(connection_status),
    .txd(txd_a[3]), .transmit_ready(rdy_a[3]), .busy(busy_a[3]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle txd for a frame whose bits (transmission order in seq[0..]) start at cycle off.
  function automatic logic [127:0] exp_wave(input logic [15:0] seq, input int nbits, input int off);
    logic [127:0] w;
    w = '1;
    for (int c = 0; c < nbits * 4; c++) w[off + c] = seq[c / 4];
    return w;
  endfunction

  function automatic logic [127:0] pulse(input int k);
    logic [127:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] span(input int start, input int len);
    logic [127:0] v;
    v = '0;
    for (int c = start; c < start + len; c++) v[c] = 1'b1;
    return v;
  endfunction

  // Request a frame now; cycle 0 is the first cycle after the launch edge.
  task automatic send_and_record(input logic [7:0] w, input int ncyc, input int drop_at,
                                 input int chg_at, input logic [7:0] chg_word);
    for (int i = 0; i < 4; i++) begin
      tx_v[i]  = '1;
      rdy_v[i] = '0;
      bsy_v[i] = '0;
    end
    word = w;
    connection_status = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        tx_v[i][k]  = txd_a[i];
        rdy_v[i][k] = rdy_a[i];
        bsy_v[i][k] = busy_a[i];
      end
      if (k == drop_at) connection_status = 1'b0;
      if (k == chg_at) word = chg_word;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    connection_status = 1'b1;
    word = 8'h50;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", 128'({txd_a, busy_a, rdy_a}), 128'(12'hF00));
    end
    rst = 1'b1;

    // 'P' = 0x50, LSB first 0,0,0,0,1,0,1,0
    send_and_record(8'h50, 48, 1, -1, 8'h00);
    check("p_none_txd",    tx_v[0],  exp_wave(16'b1010100000, 10, 0));
    check("p_none_ready",  rdy_v[0], pulse(40));
    check("p_none_busy",   bsy_v[0], span(0, 40));
    check("p_even_txd",    tx_v[1],  exp_wave(16'b10010100000, 11, 0));
    check("p_even_ready",  rdy_v[1], pulse(44));
    check("p_even_busy",   bsy_v[1], span(0, 44));
    check("p_odd_txd",     tx_v[2],  exp_wave(16'b11010100000, 11, 0));
    check("p_odd_ready",   rdy_v[2], pulse(44));
    check("p_stop2_txd",   tx_v[3],  exp_wave(16'b11010100000, 11, 0));
    check("p_stop2_ready", rdy_v[3], pulse(44));
    check("p_stop2_busy",  bsy_v[3], span(0, 44));

    // 0x07, LSB first 1,1,1,0,0,0,0,0; three ones
    send_and_record(8'h07, 48, 1, -1, 8'h00);
    check("x07_none_txd",  tx_v[0],  exp_wave(16'b1000001110, 10, 0));
    check("x07_even_txd",  tx_v[1],  exp_wave(16'b11000001110, 11, 0));
    check("x07_odd_txd",   tx_v[2],  exp_wave(16'b10000001110, 11, 0));
    check("x07_stop2_txd", tx_v[3],  exp_wave(16'b11000001110, 11, 0));
    check("x07_none_ready", rdy_v[0], pulse(40));

    // Back-to-back: 0x41 then 0x42, word changed mid-frame 1
    send_and_record(8'h41, 100, 45, 10, 8'h42);
    check("b2b_none_txd",   tx_v[0],
          exp_wave(16'b1010000010, 10, 0) & exp_wave(16'b1010000100, 10, 41));
    check("b2b_none_ready", rdy_v[0], pulse(40) | pulse(81));
    check("b2b_none_busy",  bsy_v[0], span(0, 40) | span(41, 40));
    check("b2b_even_txd",   tx_v[1],
          exp_wave(16'b10010000010, 11, 0) & exp_wave(16'b10010000100, 11, 45));
    check("b2b_even_ready", rdy_v[1], pulse(44) | pulse(89));

    // Abort during data bit 3 (cycles 16..19 of the frame)
    word = 8'h50;
    connection_status = 1'b1;
    @(negedge clk);
    repeat (17) @(negedge clk);
    check("abort_busy_before", 128'(busy_a), 128'(4'hF));
    rst = 1'b0;
    @(negedge clk);
    check("abort_lines_1", 128'({txd_a, busy_a, rdy_a}), 128'(12'hF00));
    @(negedge clk);
    check("abort_lines_2", 128'({txd_a, busy_a, rdy_a}), 128'(12'hF00));
    rst = 1'b1;
    send_and_record(8'h42, 48, 1, -1, 8'h00);
    check("post_abort_txd",   tx_v[0],  exp_wave(16'b1010000100, 10, 0));
    check("post_abort_ready", rdy_v[0], pulse(40));
    check("post_abort_even_ready", rdy_v[1], pulse(44));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
